// File: rtl/fp16_to_fp32_chn_arb.sv
// fp16_to_fp32_chn_arb
// Two-requester round-robin arbiter in front of a shared fp16->fp32
// conversion core. Each accepted operand's requester ID is pushed into an
// in-order tag FIFO; the FIFO head routes each returning result to the
// matching response port. Outstanding work is capped at MAX_OUTSTANDING.
//
// Optional feature macro: FP16_ARB_BURST_EN
//   defined   : a requester keeps priority for up to BURST_LEN consecutive
//               accepts while it holds valid.
//   undefined : priority flips on every accept (strict alternation).
//
// Ports:
//   nvdla_core_clk            clock, rising edge
//   nvdla_core_rst            synchronous active-high reset
//   req0_*/req1_*             requester operand channels (vld/rdy/pd)
//   cvt_in_*                  operand channel to the core (chn_a)
//   cvt_out_*                 result channel from the core
//   rsp0_*/rsp1_*             routed result channels (pd is broadcast)
//   busy                      tag FIFO non-empty
//   err                       sticky: result seen with empty tag FIFO
module fp16_to_fp32_chn_arb #(
    parameter int unsigned PD_IN_W         = 16,
    parameter int unsigned PD_OUT_W        = 32,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned BURST_LEN       = 4
) (
    input  logic                nvdla_core_clk,
    input  logic                nvdla_core_rst,
    input  logic                req0_vld,
    output logic                req0_rdy,
    input  logic [PD_IN_W-1:0]  req0_pd,
    input  logic                req1_vld,
    output logic                req1_rdy,
    input  logic [PD_IN_W-1:0]  req1_pd,
    output logic                cvt_in_vld,
    input  logic                cvt_in_rdy,
    output logic [PD_IN_W-1:0]  cvt_in_pd,
    input  logic                cvt_out_vld,
    output logic                cvt_out_rdy,
    input  logic [PD_OUT_W-1:0] cvt_out_pd,
    output logic                rsp0_vld,
    input  logic                rsp0_rdy,
    output logic [PD_OUT_W-1:0] rsp0_pd,
    output logic                rsp1_vld,
    input  logic                rsp1_rdy,
    output logic [PD_OUT_W-1:0] rsp1_pd,
    output logic                busy,
    output logic                err
);

    localparam int unsigned AW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUTSTANDING);

    logic                       r_prio;
    logic [MAX_OUTSTANDING-1:0] r_tag;
    logic [AW-1:0]              r_wr_ptr;
    logic [AW-1:0]              r_rd_ptr;
    logic [CW-1:0]              r_count;
    logic                       r_err;

    logic w_full;
    logic w_empty;
    logic w_gnt0;
    logic w_gnt1;
    logic w_in_vld;
    logic w_push;
    logic w_head;
    logic w_out_rdy;
    logic w_pop;
    logic w_prio_nxt;

    // full/empty come from the registered count only, so a pop never frees
    // a slot for a push in the same cycle.
    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);

    assign w_gnt1   = req1_vld & (~req0_vld | r_prio);
    assign w_gnt0   = req0_vld & (~req1_vld | ~r_prio);
    assign w_in_vld = (req0_vld | req1_vld) & ~w_full;
    assign w_push   = w_in_vld & cvt_in_rdy & ~nvdla_core_rst;

    assign w_head    = r_tag[r_rd_ptr];
    assign w_out_rdy = ~w_empty & (w_head ? rsp1_rdy : rsp0_rdy);
    assign w_pop     = cvt_out_vld & w_out_rdy & ~nvdla_core_rst;

    assign cvt_in_vld  = w_in_vld & ~nvdla_core_rst;
    assign cvt_in_pd   = w_gnt1 ? req1_pd : req0_pd;
    assign req0_rdy    = w_gnt0 & cvt_in_rdy & ~w_full & ~nvdla_core_rst;
    assign req1_rdy    = w_gnt1 & cvt_in_rdy & ~w_full & ~nvdla_core_rst;
    assign cvt_out_rdy = w_out_rdy & ~nvdla_core_rst;
    assign rsp0_vld    = cvt_out_vld & ~w_empty & ~w_head & ~nvdla_core_rst;
    assign rsp1_vld    = cvt_out_vld & ~w_empty & w_head & ~nvdla_core_rst;
    assign rsp0_pd     = cvt_out_pd;
    assign rsp1_pd     = cvt_out_pd;
    assign busy        = ~w_empty & ~nvdla_core_rst;
    assign err         = r_err & ~nvdla_core_rst;

`ifdef FP16_ARB_BURST_EN
    localparam int unsigned BW = $clog2(BURST_LEN + 1);

    logic [BW-1:0] r_burst_cnt;
    logic [BW-1:0] w_burst_nxt;
    logic [BW-1:0] w_burst_inc;

    // The counter tracks consecutive accepts of the current priority holder.
    // An accept by the other side starts a fresh burst for that requester.
    always_comb begin
        w_prio_nxt  = r_prio;
        w_burst_nxt = r_burst_cnt;
        w_burst_inc = '0;
        if (w_push) begin
            w_burst_inc = (w_gnt1 == r_prio) ? r_burst_cnt + BW'(1) : BW'(1);
            if (w_burst_inc >= BW'(BURST_LEN)) begin
                w_prio_nxt  = ~w_gnt1;
                w_burst_nxt = '0;
            end else begin
                w_prio_nxt  = w_gnt1;
                w_burst_nxt = w_burst_inc;
            end
        end else if (!(r_prio ? req1_vld : req0_vld)) begin
            w_burst_nxt = '0;
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            r_burst_cnt <= '0;
        end else begin
            r_burst_cnt <= w_burst_nxt;
        end
    end
`else
    always_comb begin
        w_prio_nxt = r_prio;
        if (w_push) begin
            w_prio_nxt = ~w_gnt1;
        end
    end
`endif

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            r_prio   <= 1'b0;
            r_tag    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_prio <= w_prio_nxt;
            if (w_push) begin
                r_tag[r_wr_ptr] <= w_gnt1;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (cvt_out_vld && w_empty) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fp16_to_fp32_chn_arb.sv
// Self-checking bench for fp16_to_fp32_chn_arb: a per-cycle vector table for
// the single-requester, routing, error and reset behaviour, followed by
// hand-written sequences for contention order and the full-FIFO stall.
module tb_fp16_to_fp32_chn_arb;

    localparam int unsigned MAXO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_vld, req1_vld, req0_rdy, req1_rdy;
    logic [15:0] req0_pd, req1_pd;
    logic        cvt_in_vld, cvt_in_rdy;
    logic [15:0] cvt_in_pd;
    logic        cvt_out_vld, cvt_out_rdy;
    logic [31:0] cvt_out_pd;
    logic        rsp0_vld, rsp0_rdy, rsp1_vld, rsp1_rdy;
    logic [31:0] rsp0_pd, rsp1_pd;
    logic        busy, err;

    always #5 clk = ~clk;

    fp16_to_fp32_chn_arb #(
        .PD_IN_W(16),
        .PD_OUT_W(32),
        .MAX_OUTSTANDING(MAXO),
        .BURST_LEN(4)
    ) dut (
        .nvdla_core_clk(clk),
        .nvdla_core_rst(rst),
        .req0_vld(req0_vld),
        .req0_rdy(req0_rdy),
        .req0_pd(req0_pd),
        .req1_vld(req1_vld),
        .req1_rdy(req1_rdy),
        .req1_pd(req1_pd),
        .cvt_in_vld(cvt_in_vld),
        .cvt_in_rdy(cvt_in_rdy),
        .cvt_in_pd(cvt_in_pd),
        .cvt_out_vld(cvt_out_vld),
        .cvt_out_rdy(cvt_out_rdy),
        .cvt_out_pd(cvt_out_pd),
        .rsp0_vld(rsp0_vld),
        .rsp0_rdy(rsp0_rdy),
        .rsp0_pd(rsp0_pd),
        .rsp1_vld(rsp1_vld),
        .rsp1_rdy(rsp1_rdy),
        .rsp1_pd(rsp1_pd),
        .busy(busy),
        .err(err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // in  = {rst, req0_vld, req1_vld, cvt_in_rdy, cvt_out_vld, rsp0_rdy, rsp1_rdy}
    // exp = {cvt_in_vld, req0_rdy, req1_rdy, cvt_out_rdy, rsp0_vld, rsp1_vld, busy, err}
    typedef struct {
        logic [6:0] in;
        logic [7:0] exp;
        logic       gnt;
    } vec_t;

    vec_t tbl[16];

    task automatic drive(input logic [6:0] in);
        {rst, req0_vld, req1_vld, cvt_in_rdy, cvt_out_vld, rsp0_rdy, rsp1_rdy} = in;
    endtask

    function automatic logic [7:0] outs();
        return {cvt_in_vld, req0_rdy, req1_rdy, cvt_out_rdy, rsp0_vld, rsp1_vld, busy, err};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic        pipe_v;
    logic        pipe_id;
    logic [15:0] pipe_pd;
    logic        exp_g;
    logic [15:0] exp_pd;

    initial begin
        tbl[0]  = '{7'b1111111, 8'b0000_0000, 1'b0}; // reset forces outputs low
        tbl[1]  = '{7'b0000011, 8'b0000_0000, 1'b0}; // idle after reset
        tbl[2]  = '{7'b0100000, 8'b1000_0000, 1'b0}; // core not ready: no rdy
        tbl[3]  = '{7'b0101000, 8'b1100_0000, 1'b0}; // accept req0
        tbl[4]  = '{7'b0011000, 8'b1010_0010, 1'b1}; // accept req1, busy
        tbl[5]  = '{7'b0000101, 8'b0000_1010, 1'b0}; // head 0, rsp0 not ready
        tbl[6]  = '{7'b0000110, 8'b0001_1010, 1'b0}; // pop to rsp0
        tbl[7]  = '{7'b0000110, 8'b0000_0110, 1'b0}; // head 1 held by rsp1_rdy=0
        tbl[8]  = '{7'b0000101, 8'b0001_0110, 1'b0}; // pop to rsp1
        tbl[9]  = '{7'b0000000, 8'b0000_0000, 1'b0}; // empty again
        tbl[10] = '{7'b0000111, 8'b0000_0000, 1'b0}; // result with empty FIFO
        tbl[11] = '{7'b0000000, 8'b0000_0001, 1'b0}; // err visible next cycle
        tbl[12] = '{7'b0011000, 8'b1010_0001, 1'b1}; // err sticky, accept req1
        tbl[13] = '{7'b0000000, 8'b0000_0011, 1'b0}; // err sticky, busy
        tbl[14] = '{7'b1100100, 8'b0000_0000, 1'b0}; // reset mid-operation
        tbl[15] = '{7'b0000000, 8'b0000_0000, 1'b0}; // cleared

        req0_pd = '0; req1_pd = '0; cvt_out_pd = '0;
        drive(7'b1000000);
        #1;

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].in);
            req0_pd    = 16'h1000 + 16'(i);
            req1_pd    = 16'h2000 + 16'(i);
            cvt_out_pd = 32'h3C00_0000 + 32'(i);
            #1;
            chk($sformatf("tbl%0d_flags", i), {24'h0, outs()}, {24'h0, tbl[i].exp});
            if (tbl[i].exp[7])
                chk($sformatf("tbl%0d_in_pd", i), {16'h0, cvt_in_pd},
                    {16'h0, (tbl[i].gnt ? 16'h2000 : 16'h1000) + 16'(i)});
            if (tbl[i].exp[3])
                chk($sformatf("tbl%0d_rsp0_pd", i), rsp0_pd, 32'h3C00_0000 + 32'(i));
            if (tbl[i].exp[2])
                chk($sformatf("tbl%0d_rsp1_pd", i), rsp1_pd, 32'h3C00_0000 + 32'(i));
            tick();
        end

        // Contention with a 1-cycle core and always-ready responses.
        drive(7'b1000000);
        tick();
        pipe_v = 1'b0; pipe_id = 1'b0; pipe_pd = '0;
        for (int k = 0; k < 16; k++) begin
            drive(7'b0111011);
            cvt_out_vld = pipe_v;
            cvt_out_pd  = {16'hF0F0, pipe_pd};
            req0_pd     = 16'h0100 + 16'(k);
            req1_pd     = 16'h0200 + 16'(k);
`ifdef FP16_ARB_BURST_EN
            exp_g = ((k / 4) % 2) == 1;
`else
            exp_g = (k % 2) == 1;
`endif
            exp_pd = (exp_g ? 16'h0200 : 16'h0100) + 16'(k);
            #1;
            chk($sformatf("rr%0d_grant", k), {30'h0, req1_rdy, req0_rdy},
                exp_g ? 32'd2 : 32'd1);
            chk($sformatf("rr%0d_in_pd", k), {16'h0, cvt_in_pd}, {16'h0, exp_pd});
            if (pipe_v) begin
                chk($sformatf("rr%0d_route", k), {29'h0, cvt_out_rdy, rsp1_vld, rsp0_vld},
                    pipe_id ? 32'd6 : 32'd5);
                chk($sformatf("rr%0d_rsp_pd", k), pipe_id ? rsp1_pd : rsp0_pd,
                    {16'hF0F0, pipe_pd});
            end
            tick();
            pipe_v = 1'b1; pipe_id = exp_g; pipe_pd = exp_pd;
        end

        // Full-FIFO stall: exactly MAXO accepts, pop does not free a slot
        // in the same cycle.
        drive(7'b1000000);
        tick();
        drive(7'b0101010);
        for (int k = 0; k < int'(MAXO); k++) begin
            #1;
            chk($sformatf("fill%0d", k), {30'h0, cvt_in_vld, req0_rdy}, 32'd3);
            tick();
        end
        #1;
        chk("full_block", {29'h0, cvt_in_vld, req0_rdy, busy}, 32'd1);
        tick();
        cvt_out_vld = 1'b1;
        #1;
        chk("full_pop", {27'h0, cvt_out_rdy, rsp0_vld, rsp1_vld, cvt_in_vld, req0_rdy},
            32'b11000);
        tick();
        cvt_out_vld = 1'b0;
        #1;
        chk("after_pop_accept", {30'h0, cvt_in_vld, req0_rdy}, 32'd3);
        tick();
        #1;
        chk("full_again", {30'h0, cvt_in_vld, busy}, 32'd1);
        drive(7'b1000000);
        tick();
        drive(7'b0000000);
        #1;
        chk("final_reset", {24'h0, outs()}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
